flight_ctrl: RTL and testbench

//  Game-rule controller driving the bird light column's push/fall inputs.

---
 rtl/flight_ctrl.sv | 133 +++++++++++++
 tb/tb_flight_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flight_ctrl
// Brief    : Game-rule controller for the bird column: key conditioning,
//            gravity pulses, collision detection, game state and score.
// Revision : 1.0  initial release
// ============================================================================
module flight_ctrl #(
  parameter int FALL_PERIOD = 25,
  parameter int SCORE_W     = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_i,
  input  logic [15:0]        lights_i,
  input  logic               pipe_at_bird_i,
  input  logic [15:0]        pipe_gap_i,
  output logic               push_o,
  output logic               fall_o,
  output logic               playing_o,
  output logic               game_over_o,
  output logic [SCORE_W-1:0] score_o
);

  localparam logic [1:0]         c_IDLE      = 2'd0;
  localparam logic [1:0]         c_PLAY      = 2'd1;
  localparam logic [1:0]         c_DEAD      = 2'd2;
  localparam int                 c_CNT_W     = $clog2(FALL_PERIOD);
  localparam logic [c_CNT_W-1:0] c_TICK      = c_CNT_W'(FALL_PERIOD - 1);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               push_q, push_d;
  logic               fall_q, fall_d;
  logic               playing_q, playing_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               ks1_q, ks2_q, kdly_q;
  logic               pipe_q;

  logic w_key_edge;
  logic w_tick;
  logic w_bad_lights;
  logic w_collide;
  logic w_die;
  logic w_pipe_passed;

  assign w_key_edge    = ks2_q & ~kdly_q;
  assign w_tick        = (cnt_q == c_TICK);
  assign w_bad_lights  = (lights_i == 16'd0) || ((lights_i & (lights_i - 16'd1)) != 16'd0);
  assign w_collide     = (lights_i[0]  & w_key_edge)
                       | (lights_i[15] & w_tick)
                       | (pipe_at_bird_i & (|(lights_i & ~pipe_gap_i)));
  assign w_die         = w_bad_lights | w_collide;
  assign w_pipe_passed = pipe_q & ~pipe_at_bird_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= c_IDLE;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      fall_q      <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= '0;
      ks1_q       <= 1'b0;
      ks2_q       <= 1'b0;
      kdly_q      <= 1'b0;
      pipe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      fall_q      <= fall_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      ks1_q       <= key_i;
      ks2_q       <= ks1_q;
      kdly_q      <= ks2_q;
      pipe_q      <= pipe_at_bird_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_key_edge) state_d = c_PLAY;
      c_PLAY:  if (w_die)      state_d = c_DEAD;
      c_DEAD:  state_d = c_DEAD;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    push_d      = 1'b0;
    fall_d      = 1'b0;
    cnt_d       = cnt_q;
    score_d     = score_q;
    playing_d   = (state_d == c_PLAY);
    game_over_d = (state_d == c_DEAD);
    case (state_q)
      c_IDLE: cnt_d = '0;
      c_PLAY: begin
        if (!w_die) begin
          // A key press wins over a coincident gravity tick and restarts the period.
          if (w_key_edge) begin
            push_d = 1'b1;
            cnt_d  = '0;
          end else if (w_tick) begin
            fall_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
          if (w_pipe_passed && (score_q != c_SCORE_MAX)) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign push_o      = push_q;
  assign fall_o      = fall_q;
  assign playing_o   = playing_q;
  assign game_over_o = game_over_q;
  assign score_o     = score_q;

endmodule
`default_nettype wire

// File: tb/tb_flight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flight_ctrl
// Brief    : Directed self-checking bench for flight_ctrl (FALL_PERIOD=4, SCORE_W=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_flight_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key;
  logic [15:0] lights;
  logic        pipe_at_bird;
  logic [15:0] pipe_gap;
  logic        push, fall, playing, game_over;
  logic [1:0]  score;

  int n_checks = 0;
  int n_errors = 0;

  flight_ctrl #(.FALL_PERIOD(4), .SCORE_W(2)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .key_i          (key),
    .lights_i       (lights),
    .pipe_at_bird_i (pipe_at_bird),
    .pipe_gap_i     (pipe_gap),
    .push_o         (push),
    .fall_o         (fall),
    .playing_o      (playing),
    .game_over_o    (game_over),
    .score_o        (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key = 1'b0;
    pipe_at_bird = 1'b0;
    pipe_gap = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Press and release the key from IDLE; returns one cycle after entering PLAY (counter = 0).
  task automatic start_game();
    key = 1'b1;
    tick();
    tick();
    chk("start_not_yet", playing, 1'b0);
    tick();
    chk("start_playing", playing, 1'b1);
    chk("start_no_push", push, 1'b0);
    key = 1'b0;
  endtask

  task automatic pass_pipe(input logic [15:0] gap);
    pipe_at_bird = 1'b1;
    pipe_gap = gap;
    tick();
    tick();
    tick();
    pipe_at_bird = 1'b0;
    tick();
  endtask

  initial begin
    lights = 16'h0100;
    do_reset();
    chk("rst_playing", playing, 1'b0);
    chk("rst_score", score, 2'd0);

    // Idle with key low: nothing happens
    for (int i = 0; i < 10; i++) tick();
    chk("idle_playing", playing, 1'b0);
    chk("idle_game_over", game_over, 1'b0);
    chk("idle_push", push, 1'b0);
    chk("idle_fall", fall, 1'b0);
    chk("idle_score", score, 2'd0);

    // Start (key held 5 cycles) and gravity every 4th cycle
    key = 1'b1;
    tick();
    tick();
    tick();
    chk("start_playing", playing, 1'b1);
    chk("start_no_push", push, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) key = 1'b0;
      chk("grav_fall", fall, (i == 4 || i == 8));
      chk("grav_push", push, 1'b0);
    end

    // Held key gives one push; next fall 4 cycles later
    key = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) key = 1'b0;
      chk("key_push", push, (i == 3));
      chk("key_fall", fall, (i == 7));
    end

    // Pipe passed through the gap scores one
    pipe_at_bird = 1'b1;
    pipe_gap = 16'h0380;
    tick();
    tick();
    tick();
    chk("pipe_in_score", score, 2'd0);
    pipe_at_bird = 1'b0;
    tick();
    chk("pipe_passed_score", score, 2'd1);
    chk("pipe_passed_playing", playing, 1'b1);

    // Pipe wall hits the bird
    pipe_at_bird = 1'b1;
    pipe_gap = 16'h0007;
    tick();
    chk("pipe_hit_over", game_over, 1'b1);
    chk("pipe_hit_playing", playing, 1'b0);
    pipe_at_bird = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dead_push", push, 1'b0);
      chk("dead_fall", fall, 1'b0);
    end
    chk("dead_score", score, 2'd1);

    // Saturating score
    lights = 16'h0100;
    do_reset();
    chk("rst2_score", score, 2'd0);
    start_game();
    for (int n = 1; n <= 4; n++) begin
      pass_pipe(16'h0100);
      chk("sat_score", score, (n > 3) ? 2'd3 : 2'(n));
    end

    // Ground collision swallows the fall pulse
    do_reset();
    start_game();
    lights = 16'h8000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("ground_fall", fall, 1'b0);
      chk("ground_over", game_over, (i >= 4));
    end

    // Ceiling collision swallows the push
    lights = 16'h0001;
    do_reset();
    start_game();
    tick();
    tick();
    tick();
    key = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("ceil_push", push, 1'b0);
      chk("ceil_over", game_over, (i >= 3));
    end
    key = 1'b0;

    // Malformed position (two bits) is fatal
    lights = 16'h0100;
    do_reset();
    start_game();
    lights = 16'h0300;
    tick();
    chk("two_hot_over", game_over, 1'b1);

    // Reset mid-game on the fall-tick cycle
    lights = 16'h0100;
    do_reset();
    start_game();
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("async_playing", playing, 1'b0);
    tick();
    chk("midrst_fall", fall, 1'b0);
    chk("midrst_push", push, 1'b0);
    chk("midrst_playing", playing, 1'b0);
    chk("midrst_over", game_over, 1'b0);
    chk("midrst_score", score, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_fall", fall, 1'b0);
    end
    chk("postrst_idle", playing, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
